ct_ifu_tage_upd_ctrl: RTL and testbench
=======================================

CT_IFU_TAGE_UPD_CTRL -- requirements
Module: ct_ifu_tage_upd_ctrl

Interface
REQ-001 SHALL have port forever_cpuclk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-002 SHALL have port cpurst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port tage_rd_vld, input, 1 bit: prediction read request.
REQ-004 SHALL have port tage_rd_index, input, 10 bits: prediction read index.
REQ-005 SHALL have port tage_rd_data_vld, output, 1 bit: read data valid.
REQ-006 SHALL have port tage_rd_data, output, 64 bits: read data, passed through from the array Q.
REQ-007 SHALL have port upd_vld, input, 1 bit: update request valid.
REQ-008 SHALL have port upd_rdy, output, 1 bit: update request ready.
REQ-009 SHALL have upd_index (input, 10 bits), upd_slot (input, 2 bits), upd_taken (input, 1 bit), upd_alloc (input, 1 bit), upd_tag (input, 11 bits), upd_u_inc (input, 1 bit) and upd_u_dec (input, 1 bit) as the update payload.
REQ-010 SHALL drive these ports to the prediction array: tage_pred_array_cen_b (output, 1 bit, active-low), tage_pred_array_gwen (output, 1 bit, active-low write), tage_pred_array_index (output, 10 bits), tage_pred_array_din (output, 64 bits), tage_pred_bwen (output, 64 bits, active-low per bit) and tage_pred_array_clk_en (output, 1 bit).
REQ-011 SHALL take array read data on port tage_pred_data_out, input, 64 bits; the array returns it one cycle after a read.

Function
REQ-012 SHALL define each 64-bit entry as 4 slots of 16 bits, slot n at bits [16n+15:16n]; within a slot, ctr is [15:13] (3-bit signed), u is [12:11] and tag is [10:0].
REQ-013 SHALL accept an update when upd_vld and upd_rdy are both high, pushing it into a 2-entry in-order FIFO; upd_rdy SHALL be low exactly when the FIFO is full.
REQ-014 SHALL run a read-modify-write sequencer with states IDLE, RD, WAIT and WR:
- IDLE to RD when the FIFO is non-empty.
- RD issues the read on a granted cycle, then goes to WAIT.
- WAIT latches tage_pred_data_out, then goes to WR.
- WR issues the write on a granted cycle, pops the FIFO, then goes to IDLE.
REQ-015 SHALL give a prediction read absolute priority: on a cycle with tage_rd_vld, the array port performs the prediction read, and a sequencer in RD or WR holds its state.
REQ-016 SHALL assert tage_rd_data_vld exactly one cycle after a cycle with tage_rd_vld high.
REQ-017 SHALL, on a read (prediction or RD), drive cen_b=0, gwen=1 and bwen all ones; on a WR write, drive cen_b=0, gwen=0, and bwen=0 only on the 16 bits of upd_slot.
REQ-018 SHALL, when upd_alloc=0, compute the new ctr as ctr+1 saturating at +3 if taken, or ctr-1 saturating at -4 if not taken.
REQ-019 SHALL, when upd_alloc=0, update u as follows:
- u_inc alone: u+1, saturating at 3.
- u_dec alone: u-1, saturating at 0.
- both or neither: u unchanged.
- tag unchanged.
REQ-020 SHALL, when upd_alloc=1, write tag=upd_tag, u=0, and ctr=0 if taken or ctr=-1 (3'b111) if not taken.
REQ-021 SHALL drive cen_b=1 on idle cycles, with the other array outputs don't-care.
REQ-022 SHALL drive tage_pred_array_clk_en=1 whenever tage_rd_vld is high, the sequencer is not in IDLE, or the FIFO is non-empty, and also in the cycle after any read.
REQ-023 SHALL allow a push and a pop in the same cycle, and SHALL keep the FIFO count unchanged when they coincide.
REQ-024 SHALL complete back-to-back updates to the same index in strict sequence, so that the second read observes the first write.
REQ-025 SHALL leave a prediction read to an index that has a pending write unforwarded: the array returns its old data.

Reset
REQ-026 SHALL, while cpurst is high, force: FIFO empty, state IDLE, upd_rdy=1, tage_rd_data_vld=0, cen_b=1, gwen=1, bwen all ones, clk_en=0.
REQ-027 SHALL, when reset is asserted mid-RMW, abandon the update; no write is issued after reset.

Structure
REQ-028 SHALL place the slot field positions, the ctr saturation limits and the state encodings in the shared package ct_ifu_tage_pkg.
REQ-029 SHALL implement the 2-entry FIFO as sub-module ct_ifu_tage_upd_fifo.

Verification
REQ-030 SHALL cover: update index 5, slot 2, taken, alloc=0, stored ctr=3'b010 -> read at cycle t, write at t+2 with ctr=3'b011, bwen zero only on [47:32], din[47:45]=3'b011.
REQ-031 SHALL cover: stored ctr=3'b011 (+3), taken -> written ctr stays 3'b011; stored ctr=3'b100 (-4), not-taken -> written ctr stays 3'b100.
REQ-032 SHALL cover: alloc=1, tag=11'h5A5, not-taken -> slot written as tag 11'h5A5, u=0, ctr=3'b111.
REQ-033 SHALL cover: tage_rd_vld held high 3 cycles while the sequencer is in WR -> the write is delayed 3 cycles, and tage_rd_data_vld pulses 3 cycles, each one cycle late.
REQ-034 SHALL cover: 3 updates offered on consecutive cycles -> upd_rdy drops after the 2nd, and the 3rd is accepted only after the first pop.
REQ-035 SHALL cover: cpurst pulsed during WAIT -> no write follows, and all outputs take their REQ-026 reset values immediately.

Source files
------------

// File: rtl/ct_ifu_tage_pkg.sv
// Shared TAGE prediction-array types: slot field layout, ctr/u limits, update request and sequencer encoding.
// Pure definitions; no timing or flow control here.
package ct_ifu_tage_pkg;

  localparam int IDX_W   = 10;
  localparam int TAG_W   = 11;
  localparam int SLOT_W  = 16;
  localparam int ENTRY_W = 64;

  localparam int CTR_MSB = 15;
  localparam int CTR_LSB = 13;
  localparam int U_MSB   = 12;
  localparam int U_LSB   = 11;
  localparam int TAG_MSB = 10;
  localparam int TAG_LSB = 0;

  localparam logic signed [2:0] CTR_MAX = 3'sb011;
  localparam logic signed [2:0] CTR_MIN = 3'sb100;
  localparam logic [1:0]        U_MAX   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2,
    ST_WR   = 2'd3
  } upd_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [1:0]       slot;
    logic             taken;
    logic             alloc;
    logic [TAG_W-1:0] tag;
    logic             u_inc;
    logic             u_dec;
  } upd_req_t;

  // New 16-bit slot contents from the old slot and one update request.
  function automatic logic [SLOT_W-1:0] slot_next(input logic [SLOT_W-1:0] old, input upd_req_t req);
    logic signed [2:0] ctr;
    logic [1:0]        u;
    logic [TAG_W-1:0]  tag;
    ctr = old[CTR_MSB:CTR_LSB];
    u   = old[U_MSB:U_LSB];
    tag = old[TAG_MSB:TAG_LSB];
    if (req.alloc) begin
      tag = req.tag;
      u   = 2'd0;
      ctr = req.taken ? 3'sb000 : 3'sb111;
    end else begin
      if (req.taken) begin
        if (ctr != CTR_MAX) ctr = ctr + 3'sd1;
      end else if (ctr != CTR_MIN) begin
        ctr = ctr - 3'sd1;
      end
      if (req.u_inc && !req.u_dec && (u != U_MAX)) u = u + 2'd1;
      else if (req.u_dec && !req.u_inc && (u != 2'd0)) u = u - 2'd1;
    end
    return {ctr, u, tag};
  endfunction

endpackage

// File: rtl/ct_ifu_tage_upd_ctrl_if.sv
// Prediction read, update request and prediction-array port bundle.
// slave = update controller side, master = fetch/array environment side.
interface ct_ifu_tage_upd_ctrl_if;
  import ct_ifu_tage_pkg::*;

  logic                 tage_rd_vld;
  logic [IDX_W-1:0]     tage_rd_index;
  logic                 tage_rd_data_vld;
  logic [ENTRY_W-1:0]   tage_rd_data;

  logic                 upd_vld;
  logic                 upd_rdy;
  logic [IDX_W-1:0]     upd_index;
  logic [1:0]           upd_slot;
  logic                 upd_taken;
  logic                 upd_alloc;
  logic [TAG_W-1:0]     upd_tag;
  logic                 upd_u_inc;
  logic                 upd_u_dec;

  logic                 tage_pred_array_cen_b;
  logic                 tage_pred_array_gwen;
  logic [IDX_W-1:0]     tage_pred_array_index;
  logic [ENTRY_W-1:0]   tage_pred_array_din;
  logic [ENTRY_W-1:0]   tage_pred_bwen;
  logic                 tage_pred_array_clk_en;
  logic [ENTRY_W-1:0]   tage_pred_data_out;

  modport slave (
    input  tage_rd_vld, tage_rd_index, upd_vld, upd_index, upd_slot, upd_taken,
           upd_alloc, upd_tag, upd_u_inc, upd_u_dec, tage_pred_data_out,
    output tage_rd_data_vld, tage_rd_data, upd_rdy, tage_pred_array_cen_b,
           tage_pred_array_gwen, tage_pred_array_index, tage_pred_array_din,
           tage_pred_bwen, tage_pred_array_clk_en
  );

  modport master (
    output tage_rd_vld, tage_rd_index, upd_vld, upd_index, upd_slot, upd_taken,
           upd_alloc, upd_tag, upd_u_inc, upd_u_dec, tage_pred_data_out,
    input  tage_rd_data_vld, tage_rd_data, upd_rdy, tage_pred_array_cen_b,
           tage_pred_array_gwen, tage_pred_array_index, tage_pred_array_din,
           tage_pred_bwen, tage_pred_array_clk_en
  );

endinterface

// File: rtl/ct_ifu_tage_upd_fifo.sv
// 2-entry in-order update request queue; head visible combinationally, push/pop take effect next edge.
// Pushes while full and pops while empty are ignored; the owner gates ready with o_full.
module ct_ifu_tage_upd_fifo
  import ct_ifu_tage_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  upd_req_t i_push_dat,
  input  logic     i_pop,
  output upd_req_t o_head_dat,
  output logic     o_full,
  output logic     o_empty
);

  upd_req_t   r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_cnt;
  logic       w_push;
  logic       w_pop;

  assign o_full     = (r_cnt == 2'd2);
  assign o_empty    = (r_cnt == 2'd0);
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_head_dat = r_mem[r_rptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_dat;
  end

endmodule

// File: rtl/ct_ifu_tage_upd_ctrl.sv
// TAGE update controller: queues updates and runs read-modify-write on the shared single-port array.
// RMW write lands 2 cycles after its read when unstalled; prediction reads always win the port; upd_rdy low when queue full.
module ct_ifu_tage_upd_ctrl
  import ct_ifu_tage_pkg::*;
(
  input  logic                   forever_cpuclk,
  input  logic                   cpurst,
  ct_ifu_tage_upd_ctrl_if.slave  bus
);

  upd_state_e         r_state;
  upd_state_e         w_state_nxt;
  logic [ENTRY_W-1:0] r_rdata;
  logic               r_rd_vld_d;
  logic               r_any_rd_d;

  upd_req_t           w_in_req;
  upd_req_t           w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_rmw_rd;
  logic [5:0]         w_slot_lsb;
  logic [ENTRY_W-1:0] w_din;
  logic [ENTRY_W-1:0] w_wmask;

  always_comb begin
    w_in_req.index = bus.upd_index;
    w_in_req.slot  = bus.upd_slot;
    w_in_req.taken = bus.upd_taken;
    w_in_req.alloc = bus.upd_alloc;
    w_in_req.tag   = bus.upd_tag;
    w_in_req.u_inc = bus.upd_u_inc;
    w_in_req.u_dec = bus.upd_u_dec;
  end

  assign bus.upd_rdy = !w_full;
  assign w_push      = bus.upd_vld && !w_full;
  // The sequencer only advances out of RD/WR when no prediction read owns the port.
  assign w_rmw_rd    = (r_state == ST_RD) && !bus.tage_rd_vld;
  assign w_pop       = (r_state == ST_WR) && !bus.tage_rd_vld;

  ct_ifu_tage_upd_fifo u_fifo (
    .i_clk      (forever_cpuclk),
    .i_rst      (cpurst),
    .i_push     (w_push),
    .i_push_dat (w_in_req),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!w_empty)          w_state_nxt = ST_RD;
      ST_RD:   if (!bus.tage_rd_vld)  w_state_nxt = ST_WAIT;
      ST_WAIT:                        w_state_nxt = ST_WR;
      ST_WR:   if (!bus.tage_rd_vld)  w_state_nxt = ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_rdata    <= '0;
      r_rd_vld_d <= 1'b0;
      r_any_rd_d <= 1'b0;
    end else begin
      if (r_state == ST_WAIT) r_rdata <= bus.tage_pred_data_out;
      r_rd_vld_d <= bus.tage_rd_vld;
      r_any_rd_d <= bus.tage_rd_vld || w_rmw_rd;
    end
  end

  assign bus.tage_rd_data_vld = r_rd_vld_d;
  assign bus.tage_rd_data     = bus.tage_pred_data_out;

  // Merge the modified slot into the latched entry; bwen keeps the other slots untouched anyway.
  always_comb begin
    w_slot_lsb = {w_head.slot, 4'b0000};
    w_din      = r_rdata;
    w_din[w_slot_lsb +: SLOT_W] = slot_next(r_rdata[w_slot_lsb +: SLOT_W], w_head);
    w_wmask    = ~({{(ENTRY_W-SLOT_W){1'b0}}, {SLOT_W{1'b1}}} << w_slot_lsb);
  end

  always_comb begin
    bus.tage_pred_array_cen_b  = 1'b1;
    bus.tage_pred_array_gwen   = 1'b1;
    bus.tage_pred_bwen         = '1;
    bus.tage_pred_array_index  = w_head.index;
    bus.tage_pred_array_din    = w_din;
    bus.tage_pred_array_clk_en = 1'b0;
    if (!cpurst) begin
      bus.tage_pred_array_clk_en = bus.tage_rd_vld || (r_state != ST_IDLE) || !w_empty || r_any_rd_d;
      if (bus.tage_rd_vld) begin
        bus.tage_pred_array_cen_b = 1'b0;
        bus.tage_pred_array_index = bus.tage_rd_index;
      end else if (r_state == ST_RD) begin
        bus.tage_pred_array_cen_b = 1'b0;
      end else if (r_state == ST_WR) begin
        bus.tage_pred_array_cen_b = 1'b0;
        bus.tage_pred_array_gwen  = 1'b0;
        bus.tage_pred_bwen        = w_wmask;
      end
    end
  end

endmodule

// File: tb/tb_ct_ifu_tage_upd_ctrl.sv
// Bench for ct_ifu_tage_upd_ctrl: array model, slot-level reference model and write/read scoreboard.
module tb_ct_ifu_tage_upd_ctrl;
  import ct_ifu_tage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ct_ifu_tage_upd_ctrl_if bus();

  ct_ifu_tage_upd_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bus            (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port array: reads return one edge later, writes honour active-low bwen.
  logic [63:0] arr_mem [1024];
  logic        pl_clr, pl_en;
  logic [9:0]  pl_idx;
  logic [63:0] pl_dat;
  always @(posedge clk) begin
    if (pl_clr) begin
      for (int i = 0; i < 1024; i++) arr_mem[i] <= '0;
    end else if (pl_en) begin
      arr_mem[pl_idx] <= pl_dat;
    end else if (!bus.tage_pred_array_cen_b) begin
      if (!bus.tage_pred_array_gwen)
        arr_mem[bus.tage_pred_array_index] <= (arr_mem[bus.tage_pred_array_index] & bus.tage_pred_bwen)
                                            | (bus.tage_pred_array_din & ~bus.tage_pred_bwen);
      else
        bus.tage_pred_data_out <= arr_mem[bus.tage_pred_array_index];
    end
  end

  // Reference image of the array after every accepted update has been applied in order.
  logic [63:0] ref_mem [1024];
  typedef struct {
    logic [9:0]  idx;
    logic [1:0]  slot;
    logic [15:0] old_s;
    logic [15:0] new_s;
  } exp_wr_t;
  exp_wr_t wq[$];
  int      wr_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_slot(input logic [15:0] old, input logic taken, input logic alloc,
                                           input logic [10:0] tag, input logic inc, input logic dec);
    int          c;
    int          u;
    logic [10:0] t;
    logic [2:0]  c3;
    logic [1:0]  u2;
    c = int'($signed(old[15:13]));
    u = int'(old[12:11]);
    t = old[10:0];
    if (alloc) begin
      t = tag;
      u = 0;
      c = taken ? 0 : -1;
    end else begin
      c = taken ? ((c < 3) ? c + 1 : 3) : ((c > -4) ? c - 1 : -4);
      if (inc && !dec)      u = (u < 3) ? u + 1 : 3;
      else if (dec && !inc) u = (u > 0) ? u - 1 : 0;
    end
    c3 = c[2:0];
    u2 = u[1:0];
    return {c3, u2, t};
  endfunction

  function automatic upd_req_t mk(input int idx, input int slot, input bit taken, input bit alloc,
                                  input int tag, input bit inc, input bit dec);
    upd_req_t r;
    r.index = idx[9:0];
    r.slot  = slot[1:0];
    r.taken = taken;
    r.alloc = alloc;
    r.tag   = tag[10:0];
    r.u_inc = inc;
    r.u_dec = dec;
    return r;
  endfunction

  // Monitor: compares every array access and read return against the scoreboard.
  int          exp_gap  = -1;
  int          rmw_rd_cyc = 0;
  int          n_rmw_rd = 0;
  int          n_wr     = 0;
  int          n_dvld   = 0;
  bit          rd_pend  = 0;
  bit          prev_rd  = 0;
  logic [63:0] rd_exp;
  always @(negedge clk) begin
    exp_wr_t     e;
    logic [63:0] m;
    if (rst) begin
      rd_pend = 0;
      prev_rd = 0;
    end else begin
      if (bus.tage_rd_data_vld) n_dvld++;
      if (rd_pend) begin
        check("rd_data_vld", 64'(bus.tage_rd_data_vld), 64'(1));
        check("rd_data", bus.tage_rd_data, rd_exp);
      end else begin
        check("rd_data_vld_idle", 64'(bus.tage_rd_data_vld), 64'(0));
      end
      rd_pend = bus.tage_rd_vld;
      rd_exp  = arr_mem[bus.tage_rd_index];
      if (bus.tage_rd_vld) begin
        check("pred_rd_cmd", {51'b0, bus.tage_pred_array_cen_b, bus.tage_pred_array_gwen, bus.tage_pred_array_index},
              {51'b0, 1'b0, 1'b1, bus.tage_rd_index});
        check("pred_rd_bwen", bus.tage_pred_bwen, {64{1'b1}});
      end else if (!bus.tage_pred_array_cen_b && bus.tage_pred_array_gwen) begin
        rmw_rd_cyc = cyc;
        n_rmw_rd++;
        check("rmw_rd_bwen", bus.tage_pred_bwen, {64{1'b1}});
        if (wq.size() > 0) check("rmw_rd_idx", 64'(bus.tage_pred_array_index), 64'(wq[0].idx));
        else               check("rmw_rd_unexpected_cen_b", 64'(bus.tage_pred_array_cen_b), 64'(1));
      end else if (!bus.tage_pred_array_cen_b) begin
        n_wr++;
        wr_log.push_back(cyc);
        if (wq.size() == 0) begin
          check("wr_unexpected_cen_b", 64'(bus.tage_pred_array_cen_b), 64'(1));
        end else begin
          e = wq.pop_front();
          m = 64'hFFFF << (16 * e.slot);
          check("wr_idx", 64'(bus.tage_pred_array_index), 64'(e.idx));
          check("wr_bwen", bus.tage_pred_bwen, ~m);
          check("wr_slot_din", 64'(bus.tage_pred_array_din[16*e.slot +: 16]), 64'(e.new_s));
          if (exp_gap >= 0) check("rd_to_wr_gap", 64'(cyc - rmw_rd_cyc), 64'(exp_gap));
        end
      end
      if (!bus.tage_pred_array_cen_b) check("clk_en_on_access", 64'(bus.tage_pred_array_clk_en), 64'(1));
      if (prev_rd)                    check("clk_en_after_rd", 64'(bus.tage_pred_array_clk_en), 64'(1));
      prev_rd = !bus.tage_pred_array_cen_b && bus.tage_pred_array_gwen;
    end
  end

  task automatic preload(input int idx, input logic [63:0] dat);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = idx[9:0]; pl_dat = dat;
    ref_mem[idx] = dat;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Presents one update and holds it until accepted; the reference model is advanced on acceptance.
  task automatic send_upd(input upd_req_t r, output int acc_cyc, output int stalls);
    logic [15:0] old_s, new_s;
    @(posedge clk); #1;
    bus.upd_vld = 1'b1;  bus.upd_index = r.index; bus.upd_slot = r.slot;
    bus.upd_taken = r.taken; bus.upd_alloc = r.alloc; bus.upd_tag = r.tag;
    bus.upd_u_inc = r.u_inc; bus.upd_u_dec = r.u_dec;
    stalls = 0;
    @(negedge clk);
    while (!bus.upd_rdy && stalls < 60) begin
      stalls++;
      @(negedge clk);
    end
    acc_cyc = cyc;
    if (!bus.upd_rdy) begin
      check("upd_accept_timeout", 64'(bus.upd_rdy), 64'(1));
    end else begin
      old_s = ref_mem[r.index][16*r.slot +: 16];
      new_s = ref_slot(old_s, r.taken, r.alloc, r.tag, r.u_inc, r.u_dec);
      ref_mem[r.index][16*r.slot +: 16] = new_s;
      wq.push_back('{idx: r.index, slot: r.slot, old_s: old_s, new_s: new_s});
    end
  endtask

  task automatic upd_idle();
    @(posedge clk); #1;
    bus.upd_vld = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (wq.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(wq.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rmw_rd(input int n0);
    int n = 0;
    @(negedge clk); #1;
    while (n_rmw_rd == n0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("rmw_rd_seen", 64'(n_rmw_rd > n0), 64'(1));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc, st, acc_c, st_b, st_c, w0, d0, n0;
    logic [63:0] v;
    upd_req_t    r;
    bit          rnd_done;

    bus.tage_rd_vld = 1'b0; bus.tage_rd_index = '0;
    bus.upd_vld = 1'b0; bus.upd_index = '0; bus.upd_slot = '0; bus.upd_taken = 1'b0;
    bus.upd_alloc = 1'b0; bus.upd_tag = '0; bus.upd_u_inc = 1'b0; bus.upd_u_dec = 1'b0;
    pl_clr = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_dat = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    @(posedge clk); #1;
    pl_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_upd_rdy",  64'(bus.upd_rdy), 64'(1));
    check("rst_dvld",     64'(bus.tage_rd_data_vld), 64'(0));
    check("rst_cen_b",    64'(bus.tage_pred_array_cen_b), 64'(1));
    check("rst_gwen",     64'(bus.tage_pred_array_gwen), 64'(1));
    check("rst_bwen",     bus.tage_pred_bwen, {64{1'b1}});
    check("rst_clk_en",   64'(bus.tage_pred_array_clk_en), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain increment: slot 2 of index 5, ctr 010 -> 011, other slots untouched.
    exp_gap = 2;
    preload(5, {16'hAAAA, 3'b010, 2'b01, 11'h123, 16'h5555, 16'h1234});
    send_upd(mk(5, 2, 1, 0, 0, 0, 0), acc, st);
    upd_idle();
    drain("drain_inc");
    check("inc_entry", arr_mem[5], {16'hAAAA, 3'b011, 2'b01, 11'h123, 16'h5555, 16'h1234});

    // Saturation at both ends.
    preload(9,  {48'h0, 3'b011, 2'b10, 11'h007});
    preload(10, {3'b100, 2'b01, 11'h3FF, 48'h0});
    send_upd(mk(9, 0, 1, 0, 0, 1, 0), acc, st);
    send_upd(mk(10, 3, 0, 0, 0, 0, 1), acc, st);
    upd_idle();
    drain("drain_sat");
    v = arr_mem[9];
    check("sat_hi_ctr", 64'(v[15:13]), 64'(3'b011));
    check("sat_hi_u",   64'(v[12:11]), 64'(2'b11));
    v = arr_mem[10];
    check("sat_lo_ctr", 64'(v[63:61]), 64'(3'b100));
    check("sat_lo_u",   64'(v[60:59]), 64'(2'b00));

    // Allocation, not taken.
    preload(11, {32'h0, 3'b010, 2'b11, 11'h0F0, 16'h0});
    send_upd(mk(11, 1, 0, 1, 'h5A5, 1, 0), acc, st);
    upd_idle();
    drain("drain_alloc");
    v = arr_mem[11];
    check("alloc_slot", 64'(v[31:16]), 64'({3'b111, 2'b00, 11'h5A5}));

    // Prediction reads held 3 cycles across WR delay the write by 3 cycles.
    exp_gap = 5;
    d0 = n_dvld;
    n0 = n_rmw_rd;
    send_upd(mk(20, 1, 1, 0, 0, 0, 0), acc, st);
    upd_idle();
    wait_rmw_rd(n0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.tage_rd_vld = 1'b1; bus.tage_rd_index = 10'd5;
    @(posedge clk); #1;
    bus.tage_rd_index = 10'd20;
    @(posedge clk); #1;
    bus.tage_rd_index = 10'd9;
    @(posedge clk); #1;
    bus.tage_rd_vld = 1'b0;
    drain("drain_stall");
    check("stall_dvld_pulses", 64'(n_dvld - d0), 64'(3));

    // Three back-to-back offers: the third waits for the first pop.
    exp_gap = 2;
    wr_log.delete();
    send_upd(mk(30, 0, 1, 0, 0, 0, 0), acc, st);
    send_upd(mk(31, 1, 0, 0, 0, 1, 0), acc, st_b);
    send_upd(mk(32, 2, 1, 0, 0, 0, 1), acc_c, st_c);
    upd_idle();
    drain("drain_b2b");
    check("b2b_second_no_stall", 64'(st_b), 64'(0));
    check("b2b_third_stalls", 64'(st_c), 64'(3));
    if (wr_log.size() > 0) check("b2b_third_after_pop", 64'(acc_c), 64'(wr_log[0] + 1));
    else                   check("b2b_first_write_seen", 64'(wr_log.size()), 64'(1));

    // Randomised updates over few indices with random prediction reads.
    exp_gap = -1;
    for (int i = 0; i < 8; i++) preload(i, {$urandom, $urandom});
    rnd_done = 0;
    fork
      begin
        for (int k = 0; k < 80; k++) begin
          r = mk($urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom), 1'($urandom_range(0, 4) == 0),
                 $urandom_range(0, 2047), 1'($urandom), 1'($urandom));
          send_upd(r, acc, st);
          if ($urandom_range(0, 2) == 0) upd_idle();
        end
        upd_idle();
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.tage_rd_vld   = ($urandom_range(0, 3) == 0);
          bus.tage_rd_index = 10'($urandom_range(0, 15));
        end
        @(posedge clk); #1;
        bus.tage_rd_vld = 1'b0;
      end
    join
    drain("drain_rand");

    // Reset while the RMW is in WAIT: update abandoned, outputs forced at once.
    n0 = n_rmw_rd;
    send_upd(mk(40, 0, 1, 0, 0, 0, 0), acc, st);
    upd_idle();
    wait_rmw_rd(n0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.tage_rd_vld = 1'b1;
    w0 = n_wr;
    #1;
    check("mid_rst_upd_rdy", 64'(bus.upd_rdy), 64'(1));
    check("mid_rst_dvld",    64'(bus.tage_rd_data_vld), 64'(0));
    check("mid_rst_cen_b",   64'(bus.tage_pred_array_cen_b), 64'(1));
    check("mid_rst_gwen",    64'(bus.tage_pred_array_gwen), 64'(1));
    check("mid_rst_bwen",    bus.tage_pred_bwen, {64{1'b1}});
    check("mid_rst_clk_en",  64'(bus.tage_pred_array_clk_en), 64'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.tage_rd_vld = 1'b0;
    for (int i = wq.size() - 1; i >= 0; i--) ref_mem[wq[i].idx][16*wq[i].slot +: 16] = wq[i].old_s;
    wq.delete();
    repeat (10) @(negedge clk);
    check("no_wr_after_rst", 64'(n_wr - w0), 64'(0));

    exp_gap = 2;
    send_upd(mk(41, 3, 0, 1, 'h123, 0, 0), acc, st);
    upd_idle();
    drain("drain_post_rst");

    for (int i = 0; i < 48; i++) check("final_mem", arr_mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
